// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester handshakes and memory pins of the two-port memory arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic          err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          busy;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, err0, err1, rdata0, rdata1, busy,
           mem_read, mem_write, mem_address, mem_data_in
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, err0, err1, rdata0, rdata1, busy,
           mem_read, mem_write, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 16,
  parameter int MEM_DEPTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t        state, state_nxt;
  logic          last_grant;
  logic          sel;
  logic          lat_we;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic          grant_any;
  logic          grant_idx;
  logic          addr_ok;
  logic [DW-1:0] rdata_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      lat_we     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_any) begin
        sel        <= grant_idx;
        last_grant <= grant_idx;
        lat_we     <= grant_idx ? bus.we1    : bus.we0;
        addr_q     <= grant_idx ? bus.addr1  : bus.addr0;
        wdata_q    <= grant_idx ? bus.wdata1 : bus.wdata0;
      end
      // Result lands in the winner's register so it is stable throughout ACK.
      if (state == ACCESS) begin
        if (sel) rdata1_q <= rdata_nxt;
        else     rdata0_q <= rdata_nxt;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_any       = bus.req0 | bus.req1;
    grant_idx       = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
    addr_ok         = 32'(addr_q) < MEM_DEPTH;
    rdata_nxt       = (!lat_we && addr_ok) ? bus.mem_data_out : '0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ack0        = 1'b0;
    bus.ack1        = 1'b0;
    bus.err0        = 1'b0;
    bus.err1        = 1'b0;
    bus.busy        = (state != IDLE);
    bus.mem_address = addr_q;
    bus.mem_data_in = wdata_q;
    bus.rdata0      = rdata0_q;
    bus.rdata1      = rdata1_q;

    case (state)
      IDLE: begin
        if (grant_any) state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.mem_write = addr_ok &  lat_we;
        bus.mem_read  = addr_ok & ~lat_we;
        state_nxt     = ACK;
      end
      ACK: begin
        bus.ack0  = ~sel;
        bus.ack1  =  sel;
        bus.err0  = ~sel & ~addr_ok;
        bus.err1  =  sel & ~addr_ok;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   ack_cnt0, ack_cnt1;
  int   exp_acks0, exp_acks1;
  logic [DW-1:0] exp_rd0, exp_rd1;
  logic [DW-1:0] mem [16];

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_DEPTH(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_data_out = bus.mem_read ? mem[bus.mem_address[3:0]] : 16'h0000;

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address[3:0]] <= bus.mem_data_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ack0) ack_cnt0++;
    if (bus.ack1) ack_cnt1++;
    check("rd_wr_exclusive", {31'b0, bus.mem_read & bus.mem_write}, 32'd0);
    check("acks_exclusive",  {31'b0, bus.ack0 & bus.ack1}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input logic exp_err);
    if (port == 0) begin
      bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end
    tick();
    check("access_busy",  {31'b0, bus.busy}, 32'd1);
    check("access_ack",   {30'b0, bus.ack1, bus.ack0}, 32'd0);
    check("access_write", {31'b0, bus.mem_write}, {31'b0, we & ~exp_err});
    check("access_read",  {31'b0, bus.mem_read}, {31'b0, ~we & ~exp_err});
    check("access_addr",  {20'b0, bus.mem_address}, {20'b0, addr});
    if (we) check("access_wdata", {16'b0, bus.mem_data_in}, {16'b0, wdata});
    tick();
    if (port == 0) begin exp_rd0 = exp_rdata; exp_acks0++; end
    else           begin exp_rd1 = exp_rdata; exp_acks1++; end
    check("ack_busy",  {31'b0, bus.busy}, 32'd1);
    check("ack_pulse", {30'b0, bus.ack1, bus.ack0}, (port == 0) ? 32'd1 : 32'd2);
    check("ack_err",   {30'b0, bus.err1, bus.err0},
          exp_err ? ((port == 0) ? 32'd1 : 32'd2) : 32'd0);
    check("ack_memrw", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rdata0",    {16'b0, bus.rdata0}, {16'b0, exp_rd0});
    check("rdata1",    {16'b0, bus.rdata1}, {16'b0, exp_rd1});
    if (port == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    tick();
    check("idle_busy", {31'b0, bus.busy}, 32'd0);
    check("idle_ack",  {30'b0, bus.ack1, bus.ack0}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack_err"}, {28'b0, bus.ack0, bus.ack1, bus.err0, bus.err1}, 32'd0);
    check({tag, "_busy_rw"}, {29'b0, bus.busy, bus.mem_read, bus.mem_write}, 32'd0);
    check({tag, "_addr"},    {20'b0, bus.mem_address}, 32'd0);
    check({tag, "_din"},     {16'b0, bus.mem_data_in}, 32'd0);
    check({tag, "_rdata"},   {bus.rdata1, bus.rdata0}, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    ack_cnt0 = 0; ack_cnt1 = 0; exp_acks0 = 0; exp_acks1 = 0;
    exp_rd0 = '0; exp_rd1 = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h0100);
    mem[2] = 16'h0007;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // 1: single read, data from mem[2]
    do_txn(0, 1'b0, 12'd2, 16'h0000, 16'h0007, 1'b0);

    // 2: write from port 1 then read back from port 0
    do_txn(1, 1'b1, 12'd3, 16'hBEEF, 16'h0000, 1'b0);
    do_txn(0, 1'b0, 12'd3, 16'h0000, 16'hBEEF, 1'b0);

    // 3: continuous dual requests after reset alternate 0,1,0,1
    rst = 1'b1;
    tick();
    check_reset_outputs("reset2");
    exp_rd0 = '0; exp_rd1 = '0;
    rst = 1'b0;
    bus.we0 = 0; bus.addr0 = 12'd2; bus.we1 = 0; bus.addr1 = 12'd3;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_access_busy", {31'b0, bus.busy}, 32'd1);
      check("rr_access_ack",  {30'b0, bus.ack1, bus.ack0}, 32'd0);
      tick();
      if (k % 2 == 0) begin exp_rd0 = 16'h0007; exp_acks0++; end
      else            begin exp_rd1 = 16'hBEEF; exp_acks1++; end
      check("rr_grant",  {30'b0, bus.ack1, bus.ack0}, (k % 2 == 0) ? 32'd1 : 32'd2);
      check("rr_rdata0", {16'b0, bus.rdata0}, {16'b0, exp_rd0});
      check("rr_rdata1", {16'b0, bus.rdata1}, {16'b0, exp_rd1});
      if (k == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      tick();
      check("rr_idle_busy", {31'b0, bus.busy}, 32'd0);
    end
    tick();
    check("rr_stays_idle", {31'b0, bus.busy}, 32'd0);

    // 4: first illegal address clears rdata1 and never touches memory
    do_txn(1, 1'b0, 12'd12, 16'h0000, 16'h0000, 1'b1);
    do_txn(1, 1'b1, 12'hFFF, 16'h1234, 16'h0000, 1'b1);
    do_txn(0, 1'b0, 12'd11, 16'h0000, 16'h0B00, 1'b0);

    // 5: reset during the ACCESS cycle of a write drops the transaction
    bus.we0 = 1'b1; bus.addr0 = 12'd1; bus.wdata0 = 16'h5A5A; bus.req0 = 1'b1;
    tick();
    check("abort_access", {30'b0, bus.busy, bus.mem_write}, 32'd3);
    rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    exp_rd0 = '0; exp_rd1 = '0;
    rst = 1'b0;
    bus.req0 = 1'b0;
    tick();
    check("abort_no_ack", {29'b0, bus.busy, bus.ack1, bus.ack0}, 32'd0);
    do_txn(0, 1'b0, 12'd2, 16'h0000, 16'h0007, 1'b0);

    tick();
    check("ack_count0", ack_cnt0, exp_acks0);
    check("ack_count1", ack_cnt1, exp_acks1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
